// File: rtl/aes_seq_pkg.sv
// Shared types and default sizing for the byte-serial AES front-end sequencer.
package aes_seq_pkg;
    localparam int AES_SEQ_BLOCK_BYTES    = 16;
    localparam int AES_SEQ_TIMEOUT_CYCLES = 4095;
    localparam int AES_SEQ_CNT_W          = $clog2(AES_SEQ_BLOCK_BYTES);

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_LOAD,
        ST_WAIT,
        ST_CAPTURE,
        ST_SEND
    } seq_state_t;
endpackage

// File: rtl/aes_byte_sequencer_if.sv
// Upstream byte-pair stream, AES core load/capture pins and downstream byte stream.
interface aes_byte_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_key;
    logic [7:0] in_data;
    logic       core_rst;
    logic [7:0] core_key;
    logic [7:0] core_din;
    logic [7:0] core_dout;
    logic       core_vld;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       err;

    modport master (
        output in_valid, in_key, in_data, core_dout, core_vld, out_ready,
        input  in_ready, core_rst, core_key, core_din, out_valid, out_data, out_last, busy, err
    );

    modport slave (
        input  in_valid, in_key, in_data, core_dout, core_vld, out_ready,
        output in_ready, core_rst, core_key, core_din, out_valid, out_data, out_last, busy, err
    );
endinterface

// File: rtl/aes_seq_bytebuf.sv
// DEPTH x W register file: synchronous write, asynchronous read, no reset (contents are
// always rewritten before use).
module aes_seq_bytebuf #(
    parameter int DEPTH = 16,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/aes_byte_sequencer.sv
// Buffers one key/plaintext block, replays it gaplessly into the AES core, captures and streams out the ciphertext.
// One block in flight; out_valid holds until accepted. Optional WAIT timeout under AES_SEQ_TIMEOUT_EN.
module aes_byte_sequencer
    import aes_seq_pkg::*;
#(
    parameter int BLOCK_BYTES    = AES_SEQ_BLOCK_BYTES,
    parameter int TIMEOUT_CYCLES = AES_SEQ_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_byte_sequencer_if.slave  bus
);
    localparam int               CNT_W = $clog2(BLOCK_BYTES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BLOCK_BYTES - 1);

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rd_idx;
    logic [15:0]      ibuf_rdata;
    logic [7:0]       obuf_rdata;
    logic             in_ready;
    logic             core_rst;
    logic [7:0]       core_key;
    logic [7:0]       core_din;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_last;
    logic             busy;
    logic             accept;

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo;
    logic             err_q;
    assign bus.err = err_q;
`else
    logic unused_tmo;
    assign unused_tmo = |TIMEOUT_CYCLES;
    assign bus.err    = 1'b0;
`endif

    assign accept = (state == ST_COLLECT) && bus.in_valid;
    // Outputs are registered, so the buffers are read one index ahead of cnt.
    assign rd_idx = (state == ST_LOAD || state == ST_SEND) ? cnt + CNT_W'(1) : '0;

    aes_seq_bytebuf #(.DEPTH(BLOCK_BYTES), .W(16)) u_ibuf (
        .clk   (clk),
        .we    (accept),
        .waddr (cnt),
        .wdata ({bus.in_key, bus.in_data}),
        .raddr (rd_idx),
        .rdata (ibuf_rdata)
    );

    aes_seq_bytebuf #(.DEPTH(BLOCK_BYTES), .W(8)) u_obuf (
        .clk   (clk),
        .we    (state == ST_CAPTURE),
        .waddr (cnt),
        .wdata (bus.core_dout),
        .raddr (rd_idx),
        .rdata (obuf_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_COLLECT;
            cnt       <= '0;
            in_ready  <= 1'b1;
            core_rst  <= 1'b1;
            core_key  <= 8'h00;
            core_din  <= 8'h00;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            busy      <= 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
            tmo       <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
`ifdef AES_SEQ_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state)
                ST_COLLECT: begin
                    if (bus.in_valid) begin
                        if (cnt == LAST) begin
                            state    <= ST_LOAD;
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            core_rst <= 1'b0;
                            core_key <= ibuf_rdata[15:8];
                            core_din <= ibuf_rdata[7:0];
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_LOAD: begin
                    if (cnt == LAST) begin
                        state    <= ST_WAIT;
                        cnt      <= '0;
                        core_key <= 8'h00;
                        core_din <= 8'h00;
`ifdef AES_SEQ_TIMEOUT_EN
                        tmo      <= '0;
`endif
                    end else begin
                        cnt      <= cnt + CNT_W'(1);
                        core_key <= ibuf_rdata[15:8];
                        core_din <= ibuf_rdata[7:0];
                    end
                end
                ST_WAIT: begin
                    if (bus.core_vld) begin
                        state <= ST_CAPTURE;
                        cnt   <= '0;
                    end
`ifdef AES_SEQ_TIMEOUT_EN
                    else if (tmo == TMO_LAST) begin
                        state    <= ST_COLLECT;
                        cnt      <= '0;
                        err_q    <= 1'b1;
                        core_rst <= 1'b1;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
`endif
                end
                ST_CAPTURE: begin
                    if (cnt == LAST) begin
                        state     <= ST_SEND;
                        cnt       <= '0;
                        core_rst  <= 1'b1;
                        out_valid <= 1'b1;
                        out_data  <= obuf_rdata;
                        out_last  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_SEND: begin
                    if (bus.out_ready) begin
                        if (cnt == LAST) begin
                            state     <= ST_COLLECT;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            out_data  <= 8'h00;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            cnt      <= cnt + CNT_W'(1);
                            out_data <= obuf_rdata;
                            out_last <= (cnt + CNT_W'(1) == LAST);
                        end
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.core_rst  = core_rst;
    assign bus.core_key  = core_key;
    assign bus.core_din  = core_din;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_last  = out_last;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_aes_byte_sequencer.sv
// Self-checking bench for aes_byte_sequencer: scenario table plus reset and timeout sequences,
// with expected core-load and output byte streams kept as queues.
module tb_aes_byte_sequencer;
    localparam int TMO = 64;
`ifdef AES_SEQ_TIMEOUT_EN
    localparam int LONG_DELAY = 40;
`else
    localparam int LONG_DELAY = 200;
`endif

    typedef struct {
        int         in_mode;    // 0 held high, 1 toggling, 2 random
        int         key_mode;   // 0 key=0x1f data=index, 1 random
        int         vld_delay;  // WAIT cycles before core_vld rises
        int         dout_mode;  // 0 ciphertext 0xA0.., 1 random
        int         rdy_mode;   // 0 always ready, 1 random 50%
        logic [7:0] exp_first;
        logic [7:0] exp_last;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_byte_sequencer_if bus();

    aes_byte_sequencer #(.BLOCK_BYTES(16), .TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [15:0] exp_load[$];
    logic [7:0]  exp_out[$];
    logic [7:0]  act_first, act_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  1);
        chk({tag, "_core_rst"},  32'(bus.core_rst),  1);
        chk({tag, "_core_key"},  32'(bus.core_key),  0);
        chk({tag, "_core_din"},  32'(bus.core_din),  0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_out_data"},  32'(bus.out_data),  0);
        chk({tag, "_out_last"},  32'(bus.out_last),  0);
        chk({tag, "_busy"},      32'(bus.busy),      0);
        chk({tag, "_err"},       32'(bus.err),       0);
    endtask

    // Offers 16 byte pairs; every pair the DUT accepts is queued as an expected core load.
    task automatic feed(input int in_mode, input int key_mode);
        int n = 0;
        int guard = 0;
        logic r, v;
        logic [7:0] k, d;
        exp_load.delete();
        while (n < 16 && guard < 400) begin
            @(negedge clk);
            guard++;
            r = bus.in_ready;
            if (guard == 1) chk("collect_ready", 32'(r), 1);
            case (in_mode)
                0:       v = 1'b1;
                1:       v = (guard % 2) == 1;
                default: v = 1'($urandom);
            endcase
            k = key_mode != 0 ? 8'($urandom) : 8'h1f;
            d = key_mode != 0 ? 8'($urandom) : n[7:0];
            bus.in_valid = v;
            bus.in_key   = k;
            bus.in_data  = d;
            if (v && r) begin
                exp_load.push_back({k, d});
                n++;
            end
        end
        chk("feed_count", 32'(n), 16);
    endtask

    // Checks 16 gapless load cycles while upstream keeps offering garbage.
    task automatic load_check();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom);
            bus.in_key   = 8'($urandom);
            bus.in_data  = 8'($urandom);
            if (i == 0) begin
                chk("load_in_ready", 32'(bus.in_ready), 0);
                chk("load_busy",     32'(bus.busy),     1);
                chk("load_core_rst", 32'(bus.core_rst), 0);
            end
            chk("core_load", 32'({bus.core_key, bus.core_din}), 32'(exp_load[i]));
        end
        @(negedge clk);
        chk("wait_core_bytes", 32'({bus.core_key, bus.core_din}), 0);
        chk("wait_core_rst",   32'(bus.core_rst), 0);
    endtask

    task automatic wait_then_vld(input int delay);
        int bad = 0;
        for (int j = 0; j < delay; j++) begin
            if (bus.out_valid || bus.err || bus.in_ready) bad++;
            @(negedge clk);
            bus.in_valid = 1'($urandom);
        end
        chk("wait_quiet", 32'(bad), 0);
        bus.core_vld = 1'b1;
    endtask

    task automatic capture(input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            bus.core_dout = exp_out[i];
        end
    endtask

    task automatic send(input int rdy_mode);
        int idx = 0;
        int guard = 0;
        logic rdy;
        @(negedge clk);
        chk("send_core_rst", 32'(bus.core_rst), 1);
        bus.core_vld  = 1'b0;
        bus.core_dout = 8'h00;
        while (idx < 16 && guard < 1000) begin
            guard++;
            chk("out_valid_held", 32'(bus.out_valid), 1);
            chk("send_in_ready",  32'(bus.in_ready),  0);
            chk("out_data",       32'(bus.out_data),  32'(exp_out[idx]));
            chk("out_last",       32'(bus.out_last),  32'(idx == 15));
            rdy = rdy_mode != 0 ? 1'($urandom) : 1'b1;
            bus.out_ready = rdy;
            bus.in_valid  = 1'($urandom);
            if (rdy) begin
                if (idx == 0)  act_first = bus.out_data;
                if (idx == 15) act_last  = bus.out_data;
                idx++;
            end
            @(negedge clk);
        end
        chk("send_count", 32'(idx), 16);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("post_in_ready",  32'(bus.in_ready),  1);
        chk("post_busy",      32'(bus.busy),      0);
        chk("post_out_valid", 32'(bus.out_valid), 0);
        chk("post_core_rst",  32'(bus.core_rst),  1);
    endtask

    task automatic run_vec(input vec_t v);
        feed(v.in_mode, v.key_mode);
        load_check();
        exp_out.delete();
        for (int i = 0; i < 16; i++)
            exp_out.push_back(v.dout_mode != 0 ? 8'($urandom) : 8'hA0 + 8'(i));
        wait_then_vld(v.vld_delay);
        capture(16);
        send(v.rdy_mode);
        if (v.dout_mode == 0) begin
            chk("first_byte", 32'(act_first), 32'(v.exp_first));
            chk("last_byte",  32'(act_last),  32'(v.exp_last));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[4];
        vec_t rv;
        vt[0] = '{0, 0, LONG_DELAY, 0, 0, 8'hA0, 8'hAF};
        vt[1] = '{1, 0, 5,          0, 1, 8'hA0, 8'hAF};
        vt[2] = '{2, 1, 0,          1, 1, 8'h00, 8'h00};
        vt[3] = '{2, 1, 17,         0, 1, 8'hA0, 8'hAF};

        bus.in_valid  = 1'b0;
        bus.in_key    = 8'h00;
        bus.in_data   = 8'h00;
        bus.core_dout = 8'h00;
        bus.core_vld  = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        for (int t = 0; t < 4; t++) run_vec(vt[t]);

        // Reset asserted mid-capture while cnt is 7.
        feed(0, 1);
        load_check();
        exp_out.delete();
        for (int i = 0; i < 16; i++) exp_out.push_back(8'hC0 + 8'(i));
        wait_then_vld(3);
        capture(7);
        @(negedge clk);
        bus.core_dout = exp_out[7];
        #1 rst = 1'b1;
        #1 chk_reset_vals("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        bus.core_vld = 1'b0;
        bus.in_valid = 1'b0;
        run_vec(vt[1]);

`ifdef AES_SEQ_TIMEOUT_EN
        begin
            int k = 0;
            int first = -1;
            int ov = 0;
            feed(0, 0);
            load_check();
            bus.in_valid = 1'b0;
            while (first < 0 && k < 300) begin
                if (bus.err) first = k;
                if (bus.out_valid) ov++;
                if (first < 0) begin
                    @(negedge clk);
                    k++;
                end
            end
            chk("tmo_err_cycle", 32'(first), 32'(TMO));
            chk("tmo_in_ready",  32'(bus.in_ready), 1);
            chk("tmo_core_rst",  32'(bus.core_rst), 1);
            @(negedge clk);
            chk("tmo_err_pulse", 32'(bus.err),  0);
            chk("tmo_busy",      32'(bus.busy), 0);
            chk("tmo_no_output", 32'(ov), 0);
        end
`endif

        for (int r = 0; r < 3; r++) begin
            rv = '{2, 1, int'($urandom_range(30, 0)), 1, 1, 8'h00, 8'h00};
            run_vec(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_byte_sequencer.md
Name: aes_byte_sequencer

Overview:
Front-end controller for the byte-serial 8-bit AES core. It buffers one 16-byte key/plaintext block from an upstream valid/ready byte stream. It then replays the block into the core on 16 back-to-back load cycles, waits for the core's done flag, captures 16 ciphertext bytes, and returns them on a downstream valid/ready byte stream. This keeps the core's load window gapless even when upstream stalls, and serialises blocks so only one is ever in flight.

Parameters:
BLOCK_BYTES, 16, bytes per block; also sizes the load, capture and send counters.
TIMEOUT_CYCLES, 4095, maximum cycles spent in WAIT before aborting (used only with the optional feature).

Ports:
clk  in  1  clock; all logic is rising-edge.
rst  in  1  asynchronous, active-high reset; forces every register to its reset value immediately.
in_valid  in  1  upstream byte pair valid.
in_ready  out  1  high in COLLECT only; transfer occurs when in_valid && in_ready.
in_key  in  8  key byte.
in_data  in  8  plaintext byte.
core_rst  out  1  reset to the AES core.
core_key  out  8  key byte to the core.
core_din  out  8  data byte to the core.
core_dout  in  8  ciphertext byte from the core.
core_vld  in  1  core done flag; sticky while the core is out of reset.
out_valid  out  1  downstream byte valid.
out_ready  in  1  downstream accept.
out_data  out  8  ciphertext byte.
out_last  out  1  high with the final byte (index 15).
busy  out  1  high in every state except COLLECT.
err  out  1  timeout abort pulse, one cycle.

Behaviour:
- States: COLLECT, LOAD, WAIT, CAPTURE, SEND. Reset state is COLLECT.
- Reset values: in_ready=1 (follows from COLLECT), core_rst=1, core_key=0, core_din=0, out_valid=0, out_data=0, out_last=0, busy=0, err=0. Byte counter = 0.
- COLLECT:
  - core_rst=1.
  - Each handshake writes {in_key, in_data} to input buffer[cnt] and increments cnt.
  - Handshake at cnt=15 → LOAD, cnt=0.
  - in_valid low does not advance cnt; gaps of any length are allowed.
- LOAD:
  - core_rst=0 from the first LOAD cycle onward.
  - core_key/core_din are registered outputs equal to buffer[cnt] on cycles 0..15, with no gaps.
  - At cnt=15 → WAIT. core_key/core_din return to 0.
- WAIT:
  - Holds until core_vld=1.
  - The first cycle that samples core_vld=1 moves to CAPTURE, cnt=0.
- CAPTURE:
  - Samples core_dout into output buffer[cnt] on 16 consecutive cycles. The first sample is the cycle after core_vld was seen.
  - After cnt=15 → SEND, cnt=0, core_rst=1.
  - The capture window is fixed; the block applies no backpressure to the core.
- SEND:
  - out_valid=1; out_data=obuf[cnt]; out_last=(cnt==15).
  - The byte is held stable until out_ready.
  - A handshake at cnt=15 → COLLECT, out_valid=0.
  - out_valid never deasserts without a handshake.
- Simultaneous events:
  - in_valid during LOAD..SEND is ignored (in_ready=0).
  - An in_valid/out_ready handshake on the COLLECT/SEND boundary cycle does not overlap; the next block's first accept occurs no earlier than one cycle after the final out handshake.
- Reset mid-operation:
  - Returns to COLLECT and discards the partial block; core_rst reasserts asynchronously.
  - Buffer contents need not be cleared.
- Counter widths: cnt is $clog2(BLOCK_BYTES) bits; the timeout counter is $clog2(TIMEOUT_CYCLES+1) bits. No wrap is permitted; state transitions occur at the terminal count.

Optional Feature:
Macro AES_SEQ_TIMEOUT_EN.
- Defined:
  - The WAIT counter increments each cycle.
  - If it reaches TIMEOUT_CYCLES with core_vld still 0: err pulses for 1 cycle, core_rst=1, and the FSM returns to COLLECT with cnt=0 and no output produced.
  - The counter clears on WAIT entry.
- Undefined:
  - WAIT waits indefinitely.
  - err is tied to 0; no timeout counter is synthesised.

Decomposition:
- Package aes_seq_pkg holds:
  - state enum (COLLECT, LOAD, WAIT, CAPTURE, SEND);
  - BLOCK_BYTES and TIMEOUT_CYCLES defaults;
  - the byte-counter width constant.
- Sub-module aes_seq_bytebuf: BLOCK_BYTES x W register file with synchronous write (we, waddr, wdata) and asynchronous read (raddr, rdata).
  - Instantiated twice: input buffer with W=16, output buffer with W=8.

Test Plan:
1. Reset then 16 pairs key=0x1f, data=0x00..0x0f with in_valid held high → in_ready drops after the 16th accept; core_key=0x1f and core_din=0x00..0x0f on 16 consecutive cycles; busy=1.
2. Same stimulus with in_valid toggling 1/0 every cycle → identical core load sequence; no gap between consecutive core_din bytes.
3. Model core raises core_vld 200 cycles after LOAD, then drives core_dout=0xA0..0xAF → out_data emits 0xA0..0xAF in order; out_last high only on 0xAF.
4. out_ready randomly low 50% of cycles during SEND → every byte is held stable while stalled; no byte is dropped or duplicated; the block returns to COLLECT after 0xAF.
5. With AES_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=64, core_vld never set → err is a 1-cycle pulse exactly 64 cycles after WAIT entry; the block returns to COLLECT with in_ready=1 and out_valid never asserted.
6. Assert rst during CAPTURE at byte 7 → all outputs take their reset values within the same cycle; the next full block produces the correct 16 bytes.
